// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared memory-access types and constants
package riscv_pkg;

    localparam int XLEN = 32;

    // Access size as decoded by the instruction controller; 2'b11 is illegal
    typedef enum logic [1:0] {
        SIZE_BYTE = 2'b00,
        SIZE_HALF = 2'b01,
        SIZE_WORD = 2'b10
    } mem_size_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        WAIT = 2'b10,
        RESP = 2'b11
    } lsu_state_t;

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - byte-lane steering, store replication, load extension and misalign check
module lsu_align
    import riscv_pkg::*;
(
    input  logic [1:0]      i_size,
    input  logic            i_unsigned,
    input  logic [1:0]      i_addr,
    input  logic [XLEN-1:0] i_wdata,
    input  logic [XLEN-1:0] i_rdata,
    output logic [3:0]      o_be,
    output logic [XLEN-1:0] o_wdata,
    output logic [XLEN-1:0] o_rdata,
    output logic            o_misalign
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Pick the addressed byte and halfword out of the raw bus word
    always_comb begin
        w_byte = i_rdata[7:0];
        case (i_addr)
            2'b00:   w_byte = i_rdata[7:0];
            2'b01:   w_byte = i_rdata[15:8];
            2'b10:   w_byte = i_rdata[23:16];
            default: w_byte = i_rdata[31:24];
        endcase
        w_half = i_addr[1] ? i_rdata[31:16] : i_rdata[15:0];
    end

    // Size-dependent enables, replicated store data, extended load data and legality
    always_comb begin
        o_be       = 4'b0000;
        o_wdata    = i_wdata;
        o_rdata    = '0;
        o_misalign = 1'b0;
        case (i_size)
            SIZE_BYTE: begin
                o_be    = 4'b0001 << i_addr;
                o_wdata = {4{i_wdata[7:0]}};
                o_rdata = i_unsigned ? {24'h000000, w_byte} : {{24{w_byte[7]}}, w_byte};
            end
            SIZE_HALF: begin
                o_be       = 4'b0011 << {i_addr[1], 1'b0};
                o_wdata    = {2{i_wdata[15:0]}};
                o_rdata    = i_unsigned ? {16'h0000, w_half} : {{16{w_half[15]}}, w_half};
                o_misalign = i_addr[0];
            end
            SIZE_WORD: begin
                o_be       = 4'b1111;
                o_wdata    = i_wdata;
                o_rdata    = i_rdata;
                o_misalign = |i_addr;
            end
            default: begin
                // Encoding 2'b11 never reaches the bus
                o_misalign = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - memory-access stage: one req/gnt/rvalid transaction per instruction
module load_store_unit
    import riscv_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int XLEN   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_is_store,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    output logic              rsp_valid,
    output logic [XLEN-1:0]   rsp_rdata,
    output logic              rsp_error,
    output logic              busy,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [XLEN-1:0]   mem_wdata,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [XLEN-1:0]   mem_rdata
);

    lsu_state_t        r_state, w_state_nxt;

    // Captured request fields needed after the accept cycle
    logic              r_is_store, w_is_store_nxt;
    logic [1:0]        r_size, w_size_nxt;
    logic              r_unsigned, w_unsigned_nxt;
    logic [1:0]        r_lane, w_lane_nxt;

    // Registered outputs
    logic              r_req_ready, w_req_ready_nxt;
    logic              r_rsp_valid, w_rsp_valid_nxt;
    logic [XLEN-1:0]   r_rsp_rdata, w_rsp_rdata_nxt;
    logic              r_rsp_error, w_rsp_error_nxt;
    logic              r_busy, w_busy_nxt;
    logic              r_mem_req, w_mem_req_nxt;
    logic              r_mem_we, w_mem_we_nxt;
    logic [ADDR_W-1:0] r_mem_addr, w_mem_addr_nxt;
    logic [3:0]        r_mem_be, w_mem_be_nxt;
    logic [XLEN-1:0]   r_mem_wdata, w_mem_wdata_nxt;

    // Alignment helper: in IDLE it looks at the live request, afterwards at the captured one
    logic [1:0]        w_al_size;
    logic              w_al_unsigned;
    logic [1:0]        w_al_lane;
    logic [3:0]        w_be;
    logic [XLEN-1:0]   w_wdata;
    logic [XLEN-1:0]   w_load_data;
    logic              w_misalign;

    assign w_al_size     = (r_state == IDLE) ? req_size     : r_size;
    assign w_al_unsigned = (r_state == IDLE) ? req_unsigned : r_unsigned;
    assign w_al_lane     = (r_state == IDLE) ? req_addr[1:0] : r_lane;

    lsu_align u_align (
        .i_size     (w_al_size),
        .i_unsigned (w_al_unsigned),
        .i_addr     (w_al_lane),
        .i_wdata    (req_wdata),
        .i_rdata    (mem_rdata),
        .o_be       (w_be),
        .o_wdata    (w_wdata),
        .o_rdata    (w_load_data),
        .o_misalign (w_misalign)
    );

    // State and all outputs update together; rst abandons any outstanding bus access
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_is_store  <= 1'b0;
            r_size      <= 2'b00;
            r_unsigned  <= 1'b0;
            r_lane      <= 2'b00;
            r_req_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_error <= 1'b0;
            r_busy      <= 1'b0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_be    <= 4'b0000;
            r_mem_wdata <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_is_store  <= w_is_store_nxt;
            r_size      <= w_size_nxt;
            r_unsigned  <= w_unsigned_nxt;
            r_lane      <= w_lane_nxt;
            r_req_ready <= w_req_ready_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_rsp_rdata <= w_rsp_rdata_nxt;
            r_rsp_error <= w_rsp_error_nxt;
            r_busy      <= w_busy_nxt;
            r_mem_req   <= w_mem_req_nxt;
            r_mem_we    <= w_mem_we_nxt;
            r_mem_addr  <= w_mem_addr_nxt;
            r_mem_be    <= w_mem_be_nxt;
            r_mem_wdata <= w_mem_wdata_nxt;
        end
    end

    // Next-state and next-output decode
    always_comb begin
        w_state_nxt     = r_state;
        w_is_store_nxt  = r_is_store;
        w_size_nxt      = r_size;
        w_unsigned_nxt  = r_unsigned;
        w_lane_nxt      = r_lane;
        w_rsp_valid_nxt = 1'b0;
        w_rsp_rdata_nxt = r_rsp_rdata;
        w_rsp_error_nxt = r_rsp_error;
        w_mem_req_nxt   = r_mem_req;
        w_mem_we_nxt    = r_mem_we;
        w_mem_addr_nxt  = r_mem_addr;
        w_mem_be_nxt    = r_mem_be;
        w_mem_wdata_nxt = r_mem_wdata;

        case (r_state)
            IDLE: begin
                if (req_valid) begin
                    w_is_store_nxt = req_is_store;
                    w_size_nxt     = req_size;
                    w_unsigned_nxt = req_unsigned;
                    w_lane_nxt     = req_addr[1:0];
                    if (w_misalign) begin
                        w_state_nxt     = RESP;
                        w_rsp_valid_nxt = 1'b1;
                        w_rsp_error_nxt = 1'b1;
                        w_rsp_rdata_nxt = '0;
                    end else begin
                        w_state_nxt     = REQ;
                        w_rsp_error_nxt = 1'b0;
                        w_mem_req_nxt   = 1'b1;
                        w_mem_we_nxt    = req_is_store;
                        w_mem_addr_nxt  = {req_addr[ADDR_W-1:2], 2'b00};
                        w_mem_be_nxt    = w_be;
                        w_mem_wdata_nxt = w_wdata;
                    end
                end
            end
            REQ: begin
                // Bus fields stay frozen until the grant
                if (mem_gnt) begin
                    w_mem_req_nxt   = 1'b0;
                    w_mem_we_nxt    = 1'b0;
                    w_mem_addr_nxt  = '0;
                    w_mem_be_nxt    = 4'b0000;
                    w_mem_wdata_nxt = '0;
                    if (mem_rvalid) begin
                        w_state_nxt     = RESP;
                        w_rsp_valid_nxt = 1'b1;
                        w_rsp_rdata_nxt = r_is_store ? '0 : w_load_data;
                    end else begin
                        w_state_nxt = WAIT;
                    end
                end
            end
            WAIT: begin
                if (mem_rvalid) begin
                    w_state_nxt     = RESP;
                    w_rsp_valid_nxt = 1'b1;
                    w_rsp_rdata_nxt = r_is_store ? '0 : w_load_data;
                end
            end
            default: begin
                // RESP: single-cycle pulse, then back to accepting
                w_state_nxt     = IDLE;
                w_rsp_rdata_nxt = '0;
                w_rsp_error_nxt = 1'b0;
            end
        endcase

        w_busy_nxt      = (w_state_nxt != IDLE);
        w_req_ready_nxt = (w_state_nxt == IDLE);
    end

    assign req_ready = r_req_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_error = r_rsp_error;
    assign busy      = r_busy;
    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_be    = r_mem_be;
    assign mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - directed self-checking bench for load_store_unit
module tb_load_store_unit;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_is_store;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_error;
    logic        busy;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    int n_tests;
    int n_fail;

    load_store_unit #(.ADDR_W(32), .XLEN(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_is_store (req_is_store),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .rsp_error    (rsp_error),
        .busy         (busy),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_be       (mem_be),
        .mem_wdata    (mem_wdata),
        .mem_gnt      (mem_gnt),
        .mem_rvalid   (mem_rvalid),
        .mem_rdata    (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req(input logic st, input logic [1:0] sz, input logic un,
                             input logic [31:0] ad, input logic [31:0] wd);
        req_is_store = st;
        req_size     = sz;
        req_unsigned = un;
        req_addr     = ad;
        req_wdata    = wd;
        req_valid    = 1'b1;
    endtask

    // Grant in REQ, rvalid on the following cycle, response three cycles after accept
    task automatic xact(input string tag, input logic st, input logic [1:0] sz, input logic un,
                        input logic [31:0] ad, input logic [31:0] wd, input logic [31:0] rd,
                        input logic [31:0] ea, input logic [3:0] ebe, input logic [31:0] ewd,
                        input logic [31:0] erd);
        check_eq({tag, "_ready"}, {31'd0, req_ready}, 32'd1);
        drive_req(st, sz, un, ad, wd);
        tick();
        req_valid = 1'b0;
        check_eq({tag, "_mreq"}, {31'd0, mem_req}, 32'd1);
        check_eq({tag, "_we"}, {31'd0, mem_we}, {31'd0, st});
        check_eq({tag, "_addr"}, mem_addr, ea);
        check_eq({tag, "_be"}, {28'd0, mem_be}, {28'd0, ebe});
        if (st) check_eq({tag, "_wdata"}, mem_wdata, ewd);
        check_eq({tag, "_busy"}, {31'd0, busy}, 32'd1);
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        check_eq({tag, "_mreq_drop"}, {31'd0, mem_req}, 32'd0);
        check_eq({tag, "_early_rsp"}, {31'd0, rsp_valid}, 32'd0);
        mem_rvalid = 1'b1;
        mem_rdata  = rd;
        tick();
        mem_rvalid = 1'b0;
        mem_rdata  = 32'h0;
        check_eq({tag, "_rsp_n3"}, {31'd0, rsp_valid}, 32'd1);
        check_eq({tag, "_err"}, {31'd0, rsp_error}, 32'd0);
        check_eq({tag, "_rdata"}, rsp_rdata, erd);
        tick();
        check_eq({tag, "_rsp_pulse"}, {31'd0, rsp_valid}, 32'd0);
        check_eq({tag, "_idle"}, {31'd0, req_ready}, 32'd1);
    endtask

    task automatic err_xact(input string tag, input logic [1:0] sz, input logic [31:0] ad);
        drive_req(1'b0, sz, 1'b0, ad, 32'h0);
        tick();
        req_valid = 1'b0;
        check_eq({tag, "_rsp_n1"}, {31'd0, rsp_valid}, 32'd1);
        check_eq({tag, "_err"}, {31'd0, rsp_error}, 32'd1);
        check_eq({tag, "_rdata"}, rsp_rdata, 32'h0);
        check_eq({tag, "_nobus"}, {31'd0, mem_req}, 32'd0);
        tick();
        check_eq({tag, "_rsp_pulse"}, {31'd0, rsp_valid}, 32'd0);
        check_eq({tag, "_nobus2"}, {31'd0, mem_req}, 32'd0);
        check_eq({tag, "_idle"}, {31'd0, req_ready}, 32'd1);
    endtask

    initial begin
        n_tests      = 0;
        n_fail       = 0;
        rst          = 1'b1;
        req_valid    = 1'b0;
        req_is_store = 1'b0;
        req_size     = 2'b00;
        req_unsigned = 1'b0;
        req_addr     = 32'h0;
        req_wdata    = 32'h0;
        mem_gnt      = 1'b0;
        mem_rvalid   = 1'b0;
        mem_rdata    = 32'h0;
        tick();
        tick();
        rst = 1'b0;

        check_eq("rst_ready", {31'd0, req_ready}, 32'd1);
        check_eq("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check_eq("rst_rdata", rsp_rdata, 32'h0);
        check_eq("rst_err", {31'd0, rsp_error}, 32'd0);
        check_eq("rst_busy", {31'd0, busy}, 32'd0);
        check_eq("rst_mreq", {31'd0, mem_req}, 32'd0);
        check_eq("rst_we", {31'd0, mem_we}, 32'd0);
        check_eq("rst_maddr", mem_addr, 32'h0);
        check_eq("rst_be", {28'd0, mem_be}, 32'h0);
        check_eq("rst_mwdata", mem_wdata, 32'h0);

        xact("lw", 1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF,
             32'h100, 4'b1111, 32'h0, 32'hDEADBEEF);
        xact("lb", 1'b0, 2'b00, 1'b0, 32'h103, 32'h0, 32'h80FF1234,
             32'h100, 4'b1000, 32'h0, 32'hFFFFFF80);
        xact("lbu", 1'b0, 2'b00, 1'b1, 32'h103, 32'h0, 32'h80FF1234,
             32'h100, 4'b1000, 32'h0, 32'h00000080);
        xact("lh", 1'b0, 2'b01, 1'b0, 32'h102, 32'h0, 32'h80017FFF,
             32'h100, 4'b1100, 32'h0, 32'hFFFF8001);
        xact("lhu0", 1'b0, 2'b01, 1'b1, 32'h100, 32'h0, 32'h80019ABC,
             32'h100, 4'b0011, 32'h0, 32'h00009ABC);
        xact("lwu", 1'b0, 2'b10, 1'b1, 32'h104, 32'h0, 32'h8000_0001,
             32'h104, 4'b1111, 32'h0, 32'h80000001);
        xact("sh", 1'b1, 2'b01, 1'b0, 32'h202, 32'h0000ABCD, 32'h12345678,
             32'h200, 4'b1100, 32'hABCDABCD, 32'h0);
        xact("sb", 1'b1, 2'b00, 1'b0, 32'h201, 32'h11223344, 32'h12345678,
             32'h200, 4'b0010, 32'h44444444, 32'h0);
        xact("sw", 1'b1, 2'b10, 1'b0, 32'h20C, 32'hCAFEF00D, 32'h0,
             32'h20C, 4'b1111, 32'hCAFEF00D, 32'h0);

        err_xact("lw_mis", 2'b10, 32'h101);
        err_xact("lw_mis2", 2'b10, 32'h102);
        err_xact("lh_mis", 2'b01, 32'h103);
        err_xact("size11", 2'b11, 32'h100);

        // Grant withheld three cycles, then grant and rvalid together
        drive_req(1'b0, 2'b01, 1'b1, 32'h302, 32'h0);
        tick();
        req_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check_eq("stall_mreq", {31'd0, mem_req}, 32'd1);
            check_eq("stall_addr", mem_addr, 32'h300);
            check_eq("stall_be", {28'd0, mem_be}, 32'hC);
            check_eq("stall_busy", {31'd0, busy}, 32'd1);
            check_eq("stall_rsp", {31'd0, rsp_valid}, 32'd0);
            tick();
        end
        mem_gnt    = 1'b1;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h80017FFF;
        tick();
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = 32'h0;
        check_eq("gntrv_rsp", {31'd0, rsp_valid}, 32'd1);
        check_eq("gntrv_rdata", rsp_rdata, 32'h00008001);
        check_eq("gntrv_mreq", {31'd0, mem_req}, 32'd0);
        tick();
        check_eq("gntrv_pulse", {31'd0, rsp_valid}, 32'd0);

        // Reset while waiting for rvalid; a late rvalid must not produce a response
        drive_req(1'b0, 2'b10, 1'b0, 32'h400, 32'h0);
        tick();
        req_valid = 1'b0;
        mem_gnt   = 1'b1;
        tick();
        mem_gnt = 1'b0;
        check_eq("wait_busy", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("rstw_mreq", {31'd0, mem_req}, 32'd0);
        check_eq("rstw_rsp", {31'd0, rsp_valid}, 32'd0);
        check_eq("rstw_busy", {31'd0, busy}, 32'd0);
        check_eq("rstw_ready", {31'd0, req_ready}, 32'd1);
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h55AA55AA;
        tick();
        mem_rvalid = 1'b0;
        check_eq("late_rv_rsp", {31'd0, rsp_valid}, 32'd0);
        check_eq("late_rv_busy", {31'd0, busy}, 32'd0);
        check_eq("late_rv_rdata", rsp_rdata, 32'h0);
        tick();
        check_eq("late_rv_rsp2", {31'd0, rsp_valid}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Memory-access stage directly downstream of the instruction controller.
- Consumes the controller's memory decode (store/load, size, signedness) plus the ALU-computed address and rs2 data.
- Performs one data-memory transaction over a req/gnt/rvalid bus and returns aligned, sign/zero-extended load data for register writeback.
- Stalls the core while a transaction is outstanding; flags misaligned or invalid accesses without touching the bus.

Parameters:
- ADDR_W, 32, byte-address width of req_addr and mem_addr.
- XLEN, 32, data width; only 32 is supported (4 byte lanes).

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, synchronous, active-high
- req_valid  in  1  stage holds a memory instruction
- req_ready  out  1  LSU can accept a request
- req_is_store  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 half, 10 word, 11 invalid (controller encoding)
- req_unsigned  in  1  zero-extend load (LBU/LHU)
- req_addr  in  ADDR_W  byte address from ALU
- req_wdata  in  XLEN  rs2 value for stores
- rsp_valid  out  1  one-cycle pulse, transaction complete
- rsp_rdata  out  XLEN  extended load data; 0 for stores and errors
- rsp_error  out  1  misaligned/invalid access, valid with rsp_valid
- busy  out  1  stall request to pipeline
- mem_req  out  1  bus request
- mem_we  out  1  bus write
- mem_addr  out  ADDR_W  word-aligned address (addr[1:0]=00)
- mem_be  out  4  byte enables
- mem_wdata  out  XLEN  lane-replicated store data
- mem_gnt  in  1  bus accepted request this cycle
- mem_rvalid  in  1  response/ack for loads and stores
- mem_rdata  in  XLEN  raw word read data

Behaviour:
- FSM states: IDLE, REQ, WAIT, RESP. All state and outputs are registered; rst forces IDLE.
- Reset values: req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_error=0, busy=0, mem_req=0, mem_we=0, mem_addr=0, mem_be=0, mem_wdata=0.
- IDLE: req_ready=1.
  - On req_valid, capture all req_* fields.
  - Misaligned or invalid access → RESP with error. Misaligned/invalid means: size=01 and addr[0]=1; size=10 and addr[1:0]≠0; or size=11.
  - Otherwise → REQ.
- REQ: mem_req=1. mem_we, mem_addr, mem_be and mem_wdata are held stable until mem_gnt.
  - gnt & rvalid in the same cycle → RESP.
  - gnt only → WAIT.
  - No gnt → stay in REQ.
- WAIT: mem_req=0. On mem_rvalid, capture the extended load data → RESP.
- RESP: rsp_valid=1 for exactly one cycle → IDLE. A new request is not accepted in RESP.
- busy=1 in every state except IDLE. req_ready = (state==IDLE).
- Byte enables:
  - byte: 0001 << addr[1:0]
  - half: 0011 << {addr[1],0}
  - word: 1111
- Store data: byte {4{wdata[7:0]}}, half {2{wdata[15:0]}}, word as-is.
- Load extraction:
  - byte lane = addr[1:0]; half lane = addr[1].
  - Sign-extend from bit 7/15 unless req_unsigned.
  - Word loads ignore req_unsigned.
- Latency: the accept cycle is N. With a same-cycle grant and rvalid on the following cycle, rsp_valid is asserted at N+3 (IDLE, REQ, WAIT, RESP). Error path: rsp_valid at N+1, no bus activity.
- mem_rvalid or mem_gnt outside REQ/WAIT is ignored.
- rst mid-transaction: at the next edge go to IDLE and drop mem_req; the outstanding bus response is discarded.
- req_valid while busy: ignored; the upstream stage must hold it.

Decomposition:
- Shared package riscv_pkg:
  - mem_size_t enum (SIZE_BYTE=2'b00, SIZE_HALF=2'b01, SIZE_WORD=2'b10), matching the controller.
  - lsu_state_t enum {IDLE, REQ, WAIT, RESP}.
  - XLEN constant.
- One combinational sub-module, lsu_align. It produces mem_be, replicated wdata, load extraction/extension and the misalign flag. The FSM lives in load_store_unit.

Test Plan:
- LW addr 0x100, mem_rdata 0xDEADBEEF, gnt in REQ, rvalid one cycle later → mem_be=1111, mem_addr=0x100, rsp_rdata=0xDEADBEEF, rsp_valid at N+3.
- LB addr 0x103, rdata 0x80FF_1234 → rsp_rdata=0xFFFFFF80. The same access with LBU → 0x00000080.
- SH addr 0x202, wdata 0x0000ABCD → mem_we=1, mem_addr=0x200, mem_be=1100, mem_wdata=0xABCDABCD, rsp_rdata=0.
- LW addr 0x101 → rsp_error=1 and rsp_valid at N+1, mem_req never asserted. The same holds for size=11.
- gnt withheld 3 cycles → mem_req stays high and mem_addr/mem_be stay stable, busy=1. gnt & rvalid together → RESP the next cycle.
- rst asserted while in WAIT → next cycle IDLE, mem_req=0, no rsp_valid pulse. A late mem_rvalid is ignored.
